// File: rtl/ap_lut_engine.sv
// rtl/ap_lut_engine.sv - bit-serial associative processor (C = B op A) driven by per-op compare/write key tables; ADD built only with AP_ADD_EN
module ap_lut_engine #(
    parameter int WORD_W = 8,
    parameter int ROWS   = 1024,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [1:0]        sel_col,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] data_out,
    input  logic              start,
    input  logic [2:0]        op,
    output logic              busy,
    output logic              irq,
    output logic              err
);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPARE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] col_a [ROWS];
    logic [WORD_W-1:0] col_b [ROWS];
    logic [WORD_W-1:0] col_c [ROWS];

    logic [ROWS-1:0]  tag_q;
    logic [ROWS-1:0]  match_vec;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [BIT_W-1:0] bit_idx;
    logic [2:0]       pass_cnt_q;
    logic [2:0]       op_q;
    logic             err_q;

    logic host_ok, op_illegal, last_pass, last_bit;
    logic key_a, key_b, key_res, use_b;
`ifdef AP_ADD_EN
    logic            key_cin, key_cout, use_cin;
    logic [ROWS-1:0] carry_q, carry_nxt_q, carry_nxt_w;
`endif

    // DONE is a resting state just like IDLE: host access and start are honoured in both
    assign host_ok  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bit_idx  = bit_cnt_q[BIT_W-1:0];
    assign last_bit = (bit_cnt_q == CNT_W'(WORD_W - 1));

    // Decide whether the requested op can run in this build
    always_comb begin
        op_illegal = (op > 3'd4);
`ifndef AP_ADD_EN
        if (op == 3'd4) op_illegal = 1'b1;
`endif
    end

    // Key table: pass number selects the operand pattern to match and the bit(s) to write
    always_comb begin
        key_a     = 1'b0;
        key_b     = 1'b0;
        key_res   = 1'b0;
        use_b     = 1'b1;
        last_pass = 1'b1;
`ifdef AP_ADD_EN
        key_cin   = 1'b0;
        key_cout  = 1'b0;
        use_cin   = 1'b0;
`endif
        case (op_q)
            3'd0: begin
                key_a = pass_cnt_q[1]; key_b = pass_cnt_q[0];
                key_res = key_a | key_b; last_pass = (pass_cnt_q == 3'd3);
            end
            3'd1: begin
                key_a = pass_cnt_q[1]; key_b = pass_cnt_q[0];
                key_res = key_a & key_b; last_pass = (pass_cnt_q == 3'd3);
            end
            3'd2: begin
                key_a = pass_cnt_q[1]; key_b = pass_cnt_q[0];
                key_res = key_a ^ key_b; last_pass = (pass_cnt_q == 3'd3);
            end
            3'd3: begin
                key_a = pass_cnt_q[0]; use_b = 1'b0;
                key_res = ~key_a; last_pass = (pass_cnt_q == 3'd1);
            end
`ifdef AP_ADD_EN
            3'd4: begin
                key_cin = pass_cnt_q[2]; key_b = pass_cnt_q[1]; key_a = pass_cnt_q[0];
                use_cin = 1'b1;
                key_res  = key_a ^ key_b ^ key_cin;
                key_cout = (key_a & key_b) | (key_a & key_cin) | (key_b & key_cin);
                last_pass = (pass_cnt_q == 3'd7);
            end
`endif
            default: last_pass = 1'b1;
        endcase
    end

    // Per-row match of the current bit slice against the pass key
    always_comb begin
        match_vec = '0;
        for (int r = 0; r < ROWS; r++) begin
            match_vec[r] = (col_a[r][bit_idx] == key_a) &&
                           (!use_b || (col_b[r][bit_idx] == key_b));
`ifdef AP_ADD_EN
            if (use_cin && (carry_q[r] != key_cin)) match_vec[r] = 1'b0;
`endif
        end
    end

`ifdef AP_ADD_EN
    // Carry-out gathered across the passes of one bit; tagged rows take this pass's carry-out
    always_comb begin
        carry_nxt_w = carry_nxt_q;
        for (int r = 0; r < ROWS; r++) begin
            if (tag_q[r]) carry_nxt_w[r] = key_cout;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = op_illegal ? S_DONE : S_CLEAR;
            S_CLEAR:        state_d = S_COMPARE;
            S_COMPARE:      state_d = S_WRITE;
            S_WRITE:        state_d = (last_pass && last_bit) ? S_DONE : S_COMPARE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state_q == S_CLEAR) || (state_q == S_COMPARE) || (state_q == S_WRITE);
        irq  = (state_q == S_DONE);
        err  = err_q;
    end

    // Sequencing registers: op latch, bit/pass counters, tags and carries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            err_q      <= 1'b0;
            bit_cnt_q  <= '0;
            pass_cnt_q <= '0;
            tag_q      <= '0;
`ifdef AP_ADD_EN
            carry_q     <= '0;
            carry_nxt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q  <= op;
                        err_q <= op_illegal;
                    end
                end
                S_CLEAR: begin
                    bit_cnt_q  <= '0;
                    pass_cnt_q <= '0;
                    tag_q      <= '0;
`ifdef AP_ADD_EN
                    carry_q     <= '0;
                    carry_nxt_q <= '0;
`endif
                end
                S_COMPARE: tag_q <= match_vec;
                S_WRITE: begin
                    tag_q <= '0;
`ifdef AP_ADD_EN
                    carry_nxt_q <= carry_nxt_w;
`endif
                    if (last_pass) begin
                        pass_cnt_q <= '0;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
`ifdef AP_ADD_EN
                        carry_q <= carry_nxt_w;
`endif
                    end else begin
                        pass_cnt_q <= pass_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Column storage: host writes when resting, C cleared and then filled bit by bit during an op
    always_ff @(posedge clk) begin
        if (host_ok && write_en) begin
            case (sel_col)
                2'd0:    col_a[addr] <= data;
                2'd1:    col_b[addr] <= data;
                2'd2:    col_c[addr] <= data;
                default: ;
            endcase
        end
        if (state_q == S_CLEAR) begin
            for (int r = 0; r < ROWS; r++) col_c[r] <= '0;
        end else if (state_q == S_WRITE) begin
            for (int r = 0; r < ROWS; r++) begin
                if (tag_q[r]) col_c[r][bit_idx] <= key_res;
            end
        end
    end

    // Host read port, live in every state
    always_comb begin
        case (sel_col)
            2'd0:    data_out = col_a[addr];
            2'd1:    data_out = col_b[addr];
            2'd2:    data_out = col_c[addr];
            default: data_out = '0;
        endcase
    end

endmodule

// File: doc/ap_lut_engine.md
Name: ap_lut_engine

Overview:
- Parametrised associative processor with three memory columns A, B and C, each ROWS x WORD_W, plus a per-row tag bit and a per-row carry bit.
- Host mode: A, B and C are loaded and read word-by-word through a single address/data port.
- Compute mode: a started operation runs bit-serially over all rows in parallel as a sequence of compare/write passes, result C = B op A.
- Sits behind the host bus wrapper as the compute core; `irq` signals completion.

Parameters:
- WORD_W, 8, bits per row word in each column.
- ROWS, 1024, rows per column.
- ADDR_W, $clog2(ROWS), host address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_en  in  1  host write strobe; honoured only in IDLE.
- sel_col  in  2  column select: 0=A, 1=B, 2=C; 3 reads as 0 and writes are dropped.
- addr  in  ADDR_W  row address.
- data  in  WORD_W  host write data.
- data_out  out  WORD_W  combinational read of column[sel_col][addr].
- start  in  1  one-cycle operation start; honoured only in IDLE.
- op  in  3  0=OR, 1=AND, 2=XOR, 3=NOT A, 4=ADD, 5-7 illegal.
- busy  out  1  high from the cycle after an accepted start until DONE.
- irq  out  1  level; set on entering DONE, cleared by the next accepted start.
- err  out  1  set with irq when op was illegal; cleared by the next accepted start.

Behaviour:
- Reset values: busy=0, irq=0, err=0, state=IDLE; tags, carries, bit_cnt, pass_cnt and op_q = 0. Column contents are not reset.
- States: IDLE, CLEAR, COMPARE, WRITE, DONE.
- IDLE:
  - write_en with sel_col<3 writes data to column[sel_col][addr].
  - start latches op into op_q, clears irq/err and goes to CLEAR, or straight to DONE with err=1 if op is illegal.
  - start and write_en in the same cycle: the write completes, then the start is accepted.
- CLEAR (1 cycle): all C rows, tags and carries set to 0; bit_cnt=0, pass_cnt=0; go to COMPARE.
- COMPARE (1 cycle):
  - Pass key = LUT[op_q][pass_cnt].
  - For every row, tag=1 iff A[bit_cnt]==keyA and B[bit_cnt]==keyB (B ignored for NOT) and, for ADD only, carry==keyCin.
  - Go to WRITE.
- WRITE (1 cycle):
  - Every tagged row writes C[bit_cnt] = key result bit; for ADD, also carry_nxt = key carry-out. All tags then clear.
  - pass_cnt increments.
  - On the last pass of a bit: bit_cnt increments, pass_cnt=0, and for ADD carry <= carry_nxt (comparisons within a bit always use the pre-bit carry).
  - If the new bit_cnt equals WORD_W go to DONE, else go to COMPARE.
- Passes per bit: OR/AND/XOR 4 (keys ab=00,01,10,11), NOT 2, ADD 8 (cin,b,a = 000..111).
- Result bits: OR/AND/XOR/NOT per the truth table; ADD sum = a^b^cin, cout = majority.
- Latency from start to irq: 2 + 2*P*WORD_W cycles, where P = passes per bit. With WORD_W=8: OR is 66 cycles, NOT 34, ADD 130. Illegal op: irq/err on the cycle after start.
- Arithmetic: ADD is modulo 2^WORD_W; the final carry is discarded.
- DONE: busy=0, irq=1; behaves as IDLE for host access and start.
- In CLEAR/COMPARE/WRITE, write_en and start are ignored; data_out stays live (C reads mid-op are undefined).
- Asynchronous reset mid-operation: immediate return to IDLE; C holds partial data; A and B are unchanged.

Optional Feature:
- Macro AP_ADD_EN.
- Defined: op=4 ADD with per-row carry storage, as specified above.
- Undefined: carry storage is not built; op=4 is illegal (irq=1, err=1 the cycle after start, C untouched).

Test Plan:
- Write A[5]=0xA5 and B[5]=0x3C, read both back -> data_out 0xA5 then 0x3C; C[5] reads 0x00 after any op starts.
- OR, AND and XOR on A[5]=0xA5, B[5]=0x3C -> C[5]=0xBD / 0x24 / 0x99; irq rises exactly 66 cycles after start; busy high for the full run.
- NOT on A[0]=0x0F and A[1023]=0xFF -> C[0]=0xF0, C[1023]=0x00; irq at cycle 34 after start.
- ADD (AP_ADD_EN defined) on A=0xFF, B=0x01 and A=0x7F, B=0x81 -> C=0x00 and 0x00 (wrap); A=0x12, B=0x34 -> C=0x46; irq at cycle 130. With the macro undefined: err=1, C unchanged.
- Illegal op=6 -> irq=err=1 on the next cycle; a subsequent legal start clears both.
- Assert rst at cycle 20 of an OR run -> busy=0 and irq=0 immediately; A and B intact; a fresh OR completes correctly. A host write issued during busy leaves the target row unchanged.
